lin_cmd_parser: RTL and testbench

//  Host-side command decoder feeding the lin_ctrl channel instances. Consumes a 32-bit AXI-Stream of host

---
 rtl/lin_cmd_parser_pkg.sv | 56 +++++
 rtl/lin_us_timer.sv | 51 +++++
 rtl/lin_cmd_parser.sv | 242 ++++++++++++++++++++++++
 tb/tb_lin_cmd_parser.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lin_cmd_parser_pkg.sv
// Shared definitions for the LIN host command parser: command codes, word field positions, parameter bundles.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package lin_cmd_parser_pkg;

    // Header word layout
    localparam logic [7:0] CMD_CFG     = 8'h01;
    localparam logic [7:0] CMD_FRM     = 8'h02;
    localparam int         HDR_CMD_LSB = 24;
    localparam int         HDR_CH_LSB  = 16;

    // CFG word1 layout
    localparam int CFG_BAUD_LSB = 0;
    localparam int CFG_MODE_BIT = 24;
    localparam int CFG_PAR_BIT  = 25;
    localparam int CFG_TERM_BIT = 26;

    // FRM word1 layout
    localparam int FRM_ID_LSB = 0;
    localparam int FRM_OP_LSB = 8;

    localparam logic [23:0] DEFAULT_BAUD = 24'd50;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CFG_W1,
        ST_FRM_W1,
        ST_FRM_W2,
        ST_FRM_W3,
        ST_WAIT_RDY,
        ST_ISSUE_CFG,
        ST_ISSUE_FRM,
        ST_DRAIN
    } state_e;

    typedef struct packed {
        logic        int_termin;
        logic        parity_type;
        logic        mode;
        logic [23:0] baudrate;
    } cfg_t;

    typedef struct packed {
        logic [1:0]  op_type;
        logic [5:0]  frame_id;
        logic [63:0] data;
    } frm_t;

    localparam cfg_t CFG_RST = '{int_termin: 1'b0, parity_type: 1'b0, mode: 1'b0, baudrate: DEFAULT_BAUD};

    // Error counter increment that sticks at all-ones
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/lin_us_timer.sv
// Inter-word watchdog: 1 us prescaler feeding a microsecond counter; compiled only with LIN_CMD_TIMEOUT_EN.
// Latency: tmo_o pulses combinationally in the cycle the TIMEOUT_VAL-th microsecond completes.
// Backpressure: none; counting restarts whenever run_i is low or clr_i is high.
`ifdef LIN_CMD_TIMEOUT_EN
module lin_us_timer #(
    parameter int CLK_FREQ    = 100000000,
    parameter int TIMEOUT_VAL = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    input  logic clr_i,
    output logic tmo_o
);

    // Clock cycles per microsecond, never below one
    localparam int unsigned TICK_DIV = (CLK_FREQ / 1000000 < 1) ? 1 : (CLK_FREQ / 1000000);

    logic [31:0] pre_q, pre_d;
    logic [31:0] us_q, us_d;
    logic        tick;

    // Prescaler and microsecond counter; both held at zero while idle or on an accepted word
    always_comb begin
        pre_d = pre_q + 32'd1;
        us_d  = us_q;
        tick  = run_i && !clr_i && (pre_q == 32'(TICK_DIV - 1));
        if (!run_i || clr_i) begin
            pre_d = '0;
            us_d  = '0;
        end else if (tick) begin
            pre_d = '0;
            us_d  = us_q + 32'd1;
        end
    end

    assign tmo_o = tick && (us_q == 32'(TIMEOUT_VAL - 1));

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
            us_q  <= '0;
        end else begin
            pre_q <= pre_d;
            us_q  <= us_d;
        end
    end

endmodule
`endif

// File: rtl/lin_cmd_parser.sv
// Host command decoder: AXI-Stream CFG/FRM commands -> single-cycle lin_config_vld / lin_frame_vld pulses.
// Latency: CFG pulse the cycle after word1; FRM pulse the cycle after lin_ready[ch] is seen high (>= 2 after word3).
// Backpressure: tready low only while waiting for lin_ready or issuing; optional LIN_CMD_TIMEOUT_EN inter-word timeout.
module lin_cmd_parser
    import lin_cmd_parser_pkg::*;
#(
    parameter int CHANNEL_NUM = 4,
    parameter int CLK_FREQ    = 100000000,
    parameter int TIMEOUT_VAL = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            s_axis_tdata,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    output logic                   s_axis_tready,
    input  logic [CHANNEL_NUM-1:0] lin_ready,
    output logic                   lin_config_vld,
    output logic [7:0]             lin_config_channel,
    output logic                   lin_mode,
    output logic [23:0]            lin_baudrate,
    output logic                   lin_parity_type,
    output logic                   lin_int_termin,
    output logic                   lin_frame_vld,
    output logic [7:0]             lin_frame_channel,
    output logic [1:0]             lin_op_type,
    output logic [5:0]             lin_frame_id,
    output logic [63:0]            lin_frame_data,
    output logic                   cmd_err,
    output logic [15:0]            cmd_err_cnt
);

    // Reject unusable parameter values at elaboration
    if (CHANNEL_NUM < 1 || CHANNEL_NUM > 256 || CLK_FREQ < 1000000 || TIMEOUT_VAL < 1) begin : g_bad_param
        $error("lin_cmd_parser: illegal parameter value");
    end

    state_e      state_q, state_d;
    logic [7:0]  ch_q, ch_d;          // channel of the command in flight
    frm_t        stg_q, stg_d;        // frame fields collected before lin_ready
    logic        cfg_vld_q, cfg_vld_d;
    logic [7:0]  cfg_ch_q, cfg_ch_d;
    cfg_t        cfg_q, cfg_d;
    logic        frm_vld_q, frm_vld_d;
    logic [7:0]  frm_ch_q, frm_ch_d;
    frm_t        frm_q, frm_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    logic        tready;
    logic        xfer;
    logic        err;
    logic        ready_sel;
    logic        tmr_tmo;
    logic [7:0]  hdr_cmd;
    logic [7:0]  hdr_ch;
    logic        hdr_ok;
    cfg_t        w_cfg;

    assign tready  = !(state_q inside {ST_WAIT_RDY, ST_ISSUE_CFG, ST_ISSUE_FRM});
    // A word arriving while reset is asserted must not raise cmd_err
    assign xfer    = s_axis_tvalid && tready && !rst;
    assign hdr_cmd = s_axis_tdata[HDR_CMD_LSB +: 8];
    assign hdr_ch  = s_axis_tdata[HDR_CH_LSB +: 8];
    assign hdr_ok  = ((hdr_cmd == CMD_CFG) || (hdr_cmd == CMD_FRM)) && ({1'b0, hdr_ch} < 9'(CHANNEL_NUM));
    assign w_cfg   = '{int_termin:  s_axis_tdata[CFG_TERM_BIT],
                       parity_type: s_axis_tdata[CFG_PAR_BIT],
                       mode:        s_axis_tdata[CFG_MODE_BIT],
                       baudrate:    s_axis_tdata[CFG_BAUD_LSB +: 24]};

    // Select lin_ready of the channel addressed by the pending frame
    always_comb begin
        ready_sel = 1'b0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            if (ch_q == 8'(i)) ready_sel = lin_ready[i];
        end
    end

`ifdef LIN_CMD_TIMEOUT_EN
    logic tmr_run;
    assign tmr_run = (state_q inside {ST_CFG_W1, ST_FRM_W1, ST_FRM_W2, ST_FRM_W3, ST_DRAIN});

    lin_us_timer #(
        .CLK_FREQ    (CLK_FREQ),
        .TIMEOUT_VAL (TIMEOUT_VAL)
    ) u_us_timer (
        .clk   (clk),
        .rst   (rst),
        .run_i (tmr_run),
        .clr_i (xfer),
        .tmo_o (tmr_tmo)
    );
`else
    assign tmr_tmo = 1'b0;
`endif

    // Command FSM: next state, field capture, pulse generation and error decision
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        stg_d     = stg_q;
        cfg_vld_d = 1'b0;
        cfg_ch_d  = cfg_ch_q;
        cfg_d     = cfg_q;
        frm_vld_d = 1'b0;
        frm_ch_d  = frm_ch_q;
        frm_d     = frm_q;
        err       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    if (s_axis_tlast) begin
                        // A one-word command is malformed and already fully consumed
                        err = 1'b1;
                    end else if (!hdr_ok) begin
                        err     = 1'b1;
                        state_d = ST_DRAIN;
                    end else begin
                        ch_d    = hdr_ch;
                        state_d = (hdr_cmd == CMD_CFG) ? ST_CFG_W1 : ST_FRM_W1;
                    end
                end
            end
            ST_CFG_W1: begin
                if (xfer) begin
                    if ((w_cfg.baudrate == 24'd0) || !s_axis_tlast) begin
                        err     = 1'b1;
                        state_d = s_axis_tlast ? ST_IDLE : ST_DRAIN;
                    end else begin
                        // Config fields go straight to the outputs together with the pulse
                        cfg_vld_d = 1'b1;
                        cfg_ch_d  = ch_q;
                        cfg_d     = w_cfg;
                        state_d   = ST_ISSUE_CFG;
                    end
                end
            end
            ST_FRM_W1: begin
                if (xfer) begin
                    stg_d.frame_id = s_axis_tdata[FRM_ID_LSB +: 6];
                    stg_d.op_type  = s_axis_tdata[FRM_OP_LSB +: 2];
                    if (s_axis_tlast) begin
                        err     = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_FRM_W2;
                    end
                end
            end
            ST_FRM_W2: begin
                if (xfer) begin
                    stg_d.data[31:0] = s_axis_tdata;
                    if (s_axis_tlast) begin
                        err     = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_FRM_W3;
                    end
                end
            end
            ST_FRM_W3: begin
                if (xfer) begin
                    stg_d.data[63:32] = s_axis_tdata;
                    if (!s_axis_tlast) begin
                        err     = 1'b1;
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_WAIT_RDY;
                    end
                end
            end
            ST_WAIT_RDY: begin
                if (ready_sel) begin
                    frm_vld_d = 1'b1;
                    frm_ch_d  = ch_q;
                    frm_d     = stg_q;
                    state_d   = ST_ISSUE_FRM;
                end
            end
            ST_ISSUE_CFG, ST_ISSUE_FRM: begin
                state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (xfer && s_axis_tlast) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A stalled stream abandons the command; an accepted word in the same cycle wins
        if (tmr_tmo && !xfer) begin
            err     = 1'b1;
            state_d = ST_IDLE;
        end

        err_cnt_d = err ? sat_inc16(err_cnt_q) : err_cnt_q;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ch_q      <= '0;
            stg_q     <= '0;
            cfg_vld_q <= 1'b0;
            cfg_ch_q  <= '0;
            cfg_q     <= CFG_RST;
            frm_vld_q <= 1'b0;
            frm_ch_q  <= '0;
            frm_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            stg_q     <= stg_d;
            cfg_vld_q <= cfg_vld_d;
            cfg_ch_q  <= cfg_ch_d;
            cfg_q     <= cfg_d;
            frm_vld_q <= frm_vld_d;
            frm_ch_q  <= frm_ch_d;
            frm_q     <= frm_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign s_axis_tready      = tready;
    assign lin_config_vld     = cfg_vld_q;
    assign lin_config_channel = cfg_ch_q;
    assign lin_mode           = cfg_q.mode;
    assign lin_baudrate       = cfg_q.baudrate;
    assign lin_parity_type    = cfg_q.parity_type;
    assign lin_int_termin     = cfg_q.int_termin;
    assign lin_frame_vld      = frm_vld_q;
    assign lin_frame_channel  = frm_ch_q;
    assign lin_op_type        = frm_q.op_type;
    assign lin_frame_id       = frm_q.frame_id;
    assign lin_frame_data     = frm_q.data;
    assign cmd_err            = err;
    assign cmd_err_cnt        = err_cnt_q;

endmodule

// File: tb/tb_lin_cmd_parser.sv
// Bench for lin_cmd_parser: table of whole commands with expected pulses/fields, plus multi-cycle sequences.
// Latency: inputs driven 1 ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: words are held valid until the parser shows tready, with a bounded wait.
module tb_lin_cmd_parser;

    localparam int CH_N = 4;
    localparam int NV   = 11;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [31:0]     s_axis_tdata  = '0;
    logic            s_axis_tvalid = 1'b0;
    logic            s_axis_tlast  = 1'b0;
    logic            s_axis_tready;
    logic [CH_N-1:0] lin_ready = '1;
    logic            lin_config_vld;
    logic [7:0]      lin_config_channel;
    logic            lin_mode;
    logic [23:0]     lin_baudrate;
    logic            lin_parity_type;
    logic            lin_int_termin;
    logic            lin_frame_vld;
    logic [7:0]      lin_frame_channel;
    logic [1:0]      lin_op_type;
    logic [5:0]      lin_frame_id;
    logic [63:0]     lin_frame_data;
    logic            cmd_err;
    logic [15:0]     cmd_err_cnt;

    always #5 clk = ~clk;

    lin_cmd_parser #(
        .CHANNEL_NUM (CH_N),
        .CLK_FREQ    (2000000),
        .TIMEOUT_VAL (5)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tlast       (s_axis_tlast),
        .s_axis_tready      (s_axis_tready),
        .lin_ready          (lin_ready),
        .lin_config_vld     (lin_config_vld),
        .lin_config_channel (lin_config_channel),
        .lin_mode           (lin_mode),
        .lin_baudrate       (lin_baudrate),
        .lin_parity_type    (lin_parity_type),
        .lin_int_termin     (lin_int_termin),
        .lin_frame_vld      (lin_frame_vld),
        .lin_frame_channel  (lin_frame_channel),
        .lin_op_type        (lin_op_type),
        .lin_frame_id       (lin_frame_id),
        .lin_frame_data     (lin_frame_data),
        .cmd_err            (cmd_err),
        .cmd_err_cnt        (cmd_err_cnt)
    );

    typedef struct {
        logic [4:0][31:0] w;
        int               n;
        logic [4:0]       lastm;
        int               ecfg;
        int               efrm;
        int               eerr;
        logic [7:0]       ech;
        logic [23:0]      ebaud;
        logic             emode;
        logic             epar;
        logic             eterm;
        logic [5:0]       eid;
        logic [1:0]       eop;
        logic [63:0]      edata;
    } vec_t;

    vec_t tv [NV];

    int n_checks = 0;
    int n_fail   = 0;

    // Pulse monitor
    int cyc = 0;
    int cfg_cnt = 0, frm_cnt = 0, err_seen = 0;
    int last_cfg_cyc = 0, prev_cfg_cyc = 0, last_frm_cyc = 0;
    int last_acc_cyc = 0;
    int c0, f0, e0, raise_cyc;

    // Reference model of held outputs
    logic [7:0]  m_cfg_ch;
    logic [23:0] m_baud;
    logic        m_mode, m_par, m_term;
    logic [7:0]  m_frm_ch;
    logic [5:0]  m_id;
    logic [1:0]  m_op;
    logic [63:0] m_data;
    logic [15:0] m_errcnt;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (lin_config_vld) begin
            cfg_cnt      <= cfg_cnt + 1;
            prev_cfg_cyc <= last_cfg_cyc;
            last_cfg_cyc <= cyc;
        end
        if (lin_frame_vld) begin
            frm_cnt      <= frm_cnt + 1;
            last_frm_cyc <= cyc;
        end
        if (cmd_err) err_seen <= err_seen + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        bit acc;
        acc = 1'b0;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            acc = s_axis_tready;
            if (acc) last_acc_cyc = cyc;
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (!acc) chk("send_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic model_reset();
        m_cfg_ch = '0; m_baud = 24'd50; m_mode = 1'b0; m_par = 1'b0; m_term = 1'b0;
        m_frm_ch = '0; m_id = '0; m_op = '0; m_data = '0; m_errcnt = '0;
    endtask

    task automatic check_fields(input string tag);
        chk({tag, "_cfg_ch"}, lin_config_channel, m_cfg_ch);
        chk({tag, "_baud"},   lin_baudrate, m_baud);
        chk({tag, "_mode"},   lin_mode, m_mode);
        chk({tag, "_parity"}, lin_parity_type, m_par);
        chk({tag, "_term"},   lin_int_termin, m_term);
        chk({tag, "_frm_ch"}, lin_frame_channel, m_frm_ch);
        chk({tag, "_id"},     lin_frame_id, m_id);
        chk({tag, "_op"},     lin_op_type, m_op);
        chk({tag, "_data"},   lin_frame_data, m_data);
        chk({tag, "_errcnt"}, cmd_err_cnt, m_errcnt);
    endtask

    function automatic vec_t mkv(input logic [31:0] w0, w1, w2, w3, w4, input int n, input logic [4:0] lastm,
                                 input int ecfg, efrm, eerr, input logic [7:0] ech, input logic [23:0] ebaud,
                                 input logic emode, epar, eterm, input logic [5:0] eid, input logic [1:0] eop,
                                 input logic [63:0] edata);
        vec_t v;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3; v.w[4] = w4;
        v.n = n; v.lastm = lastm; v.ecfg = ecfg; v.efrm = efrm; v.eerr = eerr;
        v.ech = ech; v.ebaud = ebaud; v.emode = emode; v.epar = epar; v.eterm = eterm;
        v.eid = eid; v.eop = eop; v.edata = edata;
        return v;
    endfunction

    initial begin
        //            w0            w1            w2            w3            w4        n  last     cfg frm err ch     baud        md pa tm  id     op    data
        tv[0]  = mkv(32'h01020000, 32'h03000032, 32'h0,        32'h0,        32'h0,    2, 5'b00010, 1, 0, 0, 8'd2, 24'd50,     1, 1, 0, 6'h00, 2'd0, 64'h0);
        tv[1]  = mkv(32'h02010000, 32'h00000125, 32'h44332211, 32'h88776655, 32'h0,    4, 5'b01000, 0, 1, 0, 8'd1, 24'd0,      0, 0, 0, 6'h25, 2'd1, 64'h8877665544332211);
        tv[2]  = mkv(32'h7F000000, 32'h11111111, 32'h22222222, 32'h0,        32'h0,    3, 5'b00100, 0, 0, 1, 8'd0, 24'd0,      0, 0, 0, 6'h00, 2'd0, 64'h0);
        tv[3]  = mkv(32'h02000000, 32'h0000003F, 32'hAAAAAAAA, 32'h0,        32'h0,    3, 5'b00100, 0, 0, 1, 8'd0, 24'd0,      0, 0, 0, 6'h00, 2'd0, 64'h0);
        tv[4]  = mkv(32'h01000000, 32'h04FFFFFF, 32'h0,        32'h0,        32'h0,    2, 5'b00010, 1, 0, 0, 8'd0, 24'hFFFFFF, 0, 0, 1, 6'h00, 2'd0, 64'h0);
        tv[5]  = mkv(32'h01030000, 32'h07000000, 32'h0,        32'h0,        32'h0,    2, 5'b00010, 0, 0, 1, 8'd0, 24'd0,      0, 0, 0, 6'h00, 2'd0, 64'h0);
        tv[6]  = mkv(32'h01040000, 32'h00000064, 32'h0,        32'h0,        32'h0,    2, 5'b00010, 0, 0, 1, 8'd0, 24'd0,      0, 0, 0, 6'h00, 2'd0, 64'h0);
        tv[7]  = mkv(32'h01000000, 32'h00000010, 32'h00000000, 32'h0,        32'h0,    3, 5'b00100, 0, 0, 1, 8'd0, 24'd0,      0, 0, 0, 6'h00, 2'd0, 64'h0);
        tv[8]  = mkv(32'h01010000, 32'h0,        32'h0,        32'h0,        32'h0,    1, 5'b00001, 0, 0, 1, 8'd0, 24'd0,      0, 0, 0, 6'h00, 2'd0, 64'h0);
        tv[9]  = mkv(32'h02000000, 32'h00000101, 32'h11111111, 32'h22222222, 32'h33333333, 5, 5'b10000, 0, 0, 1, 8'd0, 24'd0, 0, 0, 0, 6'h00, 2'd0, 64'h0);
        tv[10] = mkv(32'h02030000, 32'h0000023F, 32'hDEADBEEF, 32'hCAFEF00D, 32'h0,    4, 5'b01000, 0, 1, 0, 8'd3, 24'd0,      0, 0, 0, 6'h3F, 2'd2, 64'hCAFEF00DDEADBEEF);

        model_reset();
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_tready", s_axis_tready, 1);
        chk("reset_cfg_vld", lin_config_vld, 0);
        chk("reset_frm_vld", lin_frame_vld, 0);
        chk("reset_cmd_err", cmd_err, 0);
        check_fields("reset");
        @(posedge clk);
        #1;

        // Table of complete commands, lin_ready high on every channel
        for (int i = 0; i < NV; i++) begin
            c0 = cfg_cnt; f0 = frm_cnt; e0 = err_seen;
            for (int k = 0; k < tv[i].n; k++) send(tv[i].w[k], tv[i].lastm[k]);
            idle(6);
            if (tv[i].ecfg != 0) begin
                m_cfg_ch = tv[i].ech; m_baud = tv[i].ebaud; m_mode = tv[i].emode;
                m_par = tv[i].epar; m_term = tv[i].eterm;
            end
            if (tv[i].efrm != 0) begin
                m_frm_ch = tv[i].ech; m_id = tv[i].eid; m_op = tv[i].eop; m_data = tv[i].edata;
            end
            if (tv[i].eerr != 0) m_errcnt = m_errcnt + 16'd1;
            chk($sformatf("v%0d_cfg_pulses", i), 64'(cfg_cnt - c0), 64'(tv[i].ecfg));
            chk($sformatf("v%0d_frm_pulses", i), 64'(frm_cnt - f0), 64'(tv[i].efrm));
            chk($sformatf("v%0d_err_pulses", i), 64'(err_seen - e0), 64'(tv[i].eerr));
            check_fields($sformatf("v%0d", i));
            if (tv[i].ecfg != 0) chk($sformatf("v%0d_cfg_latency", i), 64'(last_cfg_cyc - last_acc_cyc), 64'd1);
            if (tv[i].efrm != 0) chk($sformatf("v%0d_frm_latency", i), 64'(last_frm_cyc - last_acc_cyc), 64'd2);
        end

        // Frame held back until its own channel becomes ready
        lin_ready = 4'b1101;
        f0 = frm_cnt; e0 = err_seen;
        send(32'h02010000, 1'b0);
        send(32'h00000125, 1'b0);
        send(32'h44332211, 1'b0);
        send(32'h88776655, 1'b1);
        idle(30);
        chk("wait_tready_low", s_axis_tready, 0);
        chk("wait_no_pulse", 64'(frm_cnt - f0), 64'd0);
        chk("wait_no_err", 64'(err_seen - e0), 64'd0);
        lin_ready = 4'b0010;
        raise_cyc = cyc;
        idle(4);
        m_frm_ch = 8'd1; m_id = 6'h25; m_op = 2'd1; m_data = 64'h8877665544332211;
        chk("wait_one_pulse", 64'(frm_cnt - f0), 64'd1);
        chk("wait_pulse_latency", 64'(last_frm_cyc - raise_cyc), 64'd1);
        chk("wait_tready_back", s_axis_tready, 1);
        check_fields("wait");
        lin_ready = '1;

        // Back-to-back CFG commands: header accepted straight after ISSUE
        c0 = cfg_cnt; e0 = err_seen;
        send(32'h01010000, 1'b0);
        send(32'h00000200, 1'b1);
        send(32'h01020000, 1'b0);
        send(32'h05000300, 1'b1);
        idle(4);
        m_cfg_ch = 8'd2; m_baud = 24'h000300; m_mode = 1'b1; m_par = 1'b0; m_term = 1'b1;
        chk("b2b_pulses", 64'(cfg_cnt - c0), 64'd2);
        chk("b2b_gap", 64'(last_cfg_cyc - prev_cfg_cyc), 64'd3);
        chk("b2b_no_err", 64'(err_seen - e0), 64'd0);
        check_fields("b2b");

`ifdef LIN_CMD_TIMEOUT_EN
        // Stall after a FRM header: 5 us at 2 cycles/us abandons the command
        e0 = err_seen; c0 = cfg_cnt;
        send(32'h02000000, 1'b0);
        idle(20);
        m_errcnt = m_errcnt + 16'd1;
        chk("tmo_err_pulse", 64'(err_seen - e0), 64'd1);
        chk("tmo_tready", s_axis_tready, 1);
        send(32'h01000000, 1'b0);
        send(32'h00000040, 1'b1);
        idle(4);
        m_cfg_ch = 8'd0; m_baud = 24'd64; m_mode = 1'b0; m_par = 1'b0; m_term = 1'b0;
        chk("tmo_next_cfg", 64'(cfg_cnt - c0), 64'd1);
        check_fields("tmo");
`endif

        // Reset in the middle of a FRM command discards it
        c0 = cfg_cnt; f0 = frm_cnt; e0 = err_seen;
        send(32'h02010000, 1'b0);
        send(32'h00000007, 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        model_reset();
        chk("mid_rst_tready", s_axis_tready, 1);
        send(32'h01030000, 1'b0);
        send(32'h02000123, 1'b1);
        idle(4);
        m_cfg_ch = 8'd3; m_baud = 24'h000123; m_par = 1'b1;
        chk("mid_rst_cfg", 64'(cfg_cnt - c0), 64'd1);
        chk("mid_rst_frm", 64'(frm_cnt - f0), 64'd0);
        chk("mid_rst_err", 64'(err_seen - e0), 64'd0);
        check_fields("mid_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
